// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types and default widths for the memory-port arbiter.
//   mem_owner_t : which requester currently owns the memory port
//   arb_state_t : arbiter sequencing state
//   starve_width: width of a counter able to hold 0..smax (at least 1 bit)
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF     = 8;
    localparam int unsigned DATA_W_DEF     = 15;
    localparam int unsigned LAT_DEF        = 1;
    localparam int unsigned STARVE_MAX_DEF = 4;

    // Latency counter width; covers LAT-1 for LAT in 1..7.
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        CORE   = 2'd1,
        LOADER = 2'd2
    } mem_owner_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int unsigned starve_width(input int unsigned smax);
        int unsigned w;
        w = $clog2(smax + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick
//   Combinational owner selection between the core and the loader, plus the
//   next value of the starvation counter for the grant being made.
//   core_req, ld_req : pending requests
//   starve           : consecutive core grants made while the loader waited
//   winner           : NONE when nobody requests, else CORE or LOADER
//   starve_next      : counter value to load when the grant is taken
module arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned SW         = starve_width(STARVE_MAX)
) (
    input  logic          core_req,
    input  logic          ld_req,
    input  logic [SW-1:0] starve,
    output mem_owner_t    winner,
    output logic [SW-1:0] starve_next
);

    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    always_comb begin
        winner      = NONE;
        starve_next = starve;
        if (ld_req && (!core_req || (starve == SMAX))) begin
            winner      = LOADER;
            starve_next = '0;
        end else if (core_req) begin
            winner = CORE;
            if (ld_req) begin
                // Saturating count of core wins over a waiting loader.
                starve_next = (starve == SMAX) ? SMAX : (starve + 1'b1);
            end else begin
                starve_next = '0;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between the processor core and the loader/debug
//   port. Each access is granted from IDLE, held on the memory port for LAT
//   cycles, then completed with a one-cycle done pulse.
//   ph1, reset                 : clock, asynchronous active-high reset
//   core_req/we/adr/wdata      : core access request
//   core_gnt, core_done        : core accept / complete pulses
//   core_stall                 : core must hold (core_req & ~core_done)
//   ld_req/we/adr/wdata        : loader access request
//   ld_gnt, ld_done            : loader accept / complete pulses
//   rdata                      : read data, updated on read completion
//   mem_adr/we/wdata, mem_rdata: external memory port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned LAT        = LAT_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              ph1,
    input  logic              reset,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_adr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_done,
    output logic              core_stall,

    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_adr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_done,

    output logic [DATA_W-1:0] rdata,

    output logic [ADDR_W-1:0] mem_adr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned    SW       = starve_width(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

    arb_state_t       state;
    mem_owner_t       owner;
    logic [CNT_W-1:0] cnt;
    logic [SW-1:0]    starve;

    mem_owner_t       winner;
    logic [SW-1:0]    starve_next;

    arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .SW         (SW)
    ) u_pick (
        .core_req    (core_req),
        .ld_req      (ld_req),
        .starve      (starve),
        .winner      (winner),
        .starve_next (starve_next)
    );

    assign core_stall = core_req & ~core_done;

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= NONE;
            cnt       <= '0;
            starve    <= '0;
            rdata     <= '0;
            mem_adr   <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            core_gnt  <= 1'b0;
            core_done <= 1'b0;
            ld_gnt    <= 1'b0;
            ld_done   <= 1'b0;
        end else begin
            core_gnt  <= 1'b0;
            core_done <= 1'b0;
            ld_gnt    <= 1'b0;
            ld_done   <= 1'b0;

            case (state)
                IDLE: begin
                    if (winner != NONE) begin
                        owner  <= winner;
                        starve <= starve_next;
                        cnt    <= CNT_INIT;
                        state  <= BUSY;
                        if (winner == LOADER) begin
                            ld_gnt    <= 1'b1;
                            mem_adr   <= ld_adr;
                            mem_we    <= ld_we;
                            mem_wdata <= ld_wdata;
                        end else begin
                            core_gnt  <= 1'b1;
                            mem_adr   <= core_adr;
                            mem_we    <= core_we;
                            mem_wdata <= core_wdata;
                        end
                    end
                end

                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        // mem_rdata is valid on the last access cycle only.
                        if (!mem_we) begin
                            rdata <= mem_rdata;
                        end
                        if (owner == LOADER) begin
                            ld_done <= 1'b1;
                        end else begin
                            core_done <= 1'b1;
                        end
                        mem_we <= 1'b0;
                        owner  <= NONE;
                        state  <= IDLE;
                    end
                end

                default: begin
                    state  <= IDLE;
                    owner  <= NONE;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Drives two arbiters (LAT=1 and LAT=3) with the same directed stimulus and
//   checks them against a transaction-level model plus literal expectations.
module tb_mem_arbiter;

    localparam int AW   = 8;
    localparam int DW   = 15;
    localparam int SMAX = 4;
    localparam int LATS [2] = '{1, 3};

    logic          ph1;
    logic          reset;
    logic          core_req, core_we, ld_req, ld_we;
    logic [AW-1:0] core_adr, ld_adr;
    logic [DW-1:0] core_wdata, ld_wdata, mem_rdata;

    logic [1:0]    core_gnt_o, core_done_o, core_stall_o;
    logic [1:0]    ld_gnt_o, ld_done_o, mem_we_o;
    logic [DW-1:0] rdata_o     [2];
    logic [AW-1:0] mem_adr_o   [2];
    logic [DW-1:0] mem_wdata_o [2];

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(1), .STARVE_MAX(SMAX)) u1 (
        .ph1(ph1), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_adr(core_adr), .core_wdata(core_wdata),
        .core_gnt(core_gnt_o[0]), .core_done(core_done_o[0]), .core_stall(core_stall_o[0]),
        .ld_req(ld_req), .ld_we(ld_we), .ld_adr(ld_adr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt_o[0]), .ld_done(ld_done_o[0]),
        .rdata(rdata_o[0]),
        .mem_adr(mem_adr_o[0]), .mem_we(mem_we_o[0]), .mem_wdata(mem_wdata_o[0]),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(3), .STARVE_MAX(SMAX)) u3 (
        .ph1(ph1), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_adr(core_adr), .core_wdata(core_wdata),
        .core_gnt(core_gnt_o[1]), .core_done(core_done_o[1]), .core_stall(core_stall_o[1]),
        .ld_req(ld_req), .ld_we(ld_we), .ld_adr(ld_adr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt_o[1]), .ld_done(ld_done_o[1]),
        .rdata(rdata_o[1]),
        .mem_adr(mem_adr_o[1]), .mem_we(mem_we_o[1]), .mem_wdata(mem_wdata_o[1]),
        .mem_rdata(mem_rdata)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[lat=%0d] got=%0h exp=%0h", nm, LATS[k], act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // rem = cycles left until the current access completes (0 = port free).
    int            m_rem    [2];
    int            m_owner  [2];   // 1 core, 2 loader
    int            m_starve [2];
    logic          m_cg [2], m_lg [2], m_cd [2], m_ldn [2], m_we [2];
    logic [AW-1:0] m_adr [2];
    logic [DW-1:0] m_wd [2], m_rd [2];

    initial begin
        bit lw;
        forever begin
            @(posedge ph1 or posedge reset);
            for (int k = 0; k < 2; k++) begin
                m_cg[k] = 0; m_lg[k] = 0; m_cd[k] = 0; m_ldn[k] = 0;
                if (reset) begin
                    m_rem[k] = 0; m_owner[k] = 0; m_starve[k] = 0;
                    m_we[k] = 0; m_adr[k] = '0; m_wd[k] = '0; m_rd[k] = '0;
                end else if (m_rem[k] == 0) begin
                    if (core_req || ld_req) begin
                        lw = ld_req && (!core_req || m_starve[k] == SMAX);
                        if (lw) begin
                            m_lg[k] = 1; m_owner[k] = 2; m_starve[k] = 0;
                            m_adr[k] = ld_adr; m_we[k] = ld_we; m_wd[k] = ld_wdata;
                        end else begin
                            m_cg[k] = 1; m_owner[k] = 1;
                            m_starve[k] = ld_req ? ((m_starve[k] + 1 > SMAX) ? SMAX : m_starve[k] + 1) : 0;
                            m_adr[k] = core_adr; m_we[k] = core_we; m_wd[k] = core_wdata;
                        end
                        m_rem[k] = LATS[k];
                    end
                end else begin
                    m_rem[k]--;
                    if (m_rem[k] == 0) begin
                        if (!m_we[k]) m_rd[k] = mem_rdata;
                        if (m_owner[k] == 2) m_ldn[k] = 1; else m_cd[k] = 1;
                        m_we[k] = 0;
                        m_owner[k] = 0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_en = 0;
    always @(negedge ph1) begin
        if (cmp_en && !reset) begin
            for (int k = 0; k < 2; k++) begin
                chk("core_gnt",   k, 32'(core_gnt_o[k]),   32'(m_cg[k]));
                chk("ld_gnt",     k, 32'(ld_gnt_o[k]),     32'(m_lg[k]));
                chk("core_done",  k, 32'(core_done_o[k]),  32'(m_cd[k]));
                chk("ld_done",    k, 32'(ld_done_o[k]),    32'(m_ldn[k]));
                chk("core_stall", k, 32'(core_stall_o[k]), 32'(core_req & ~m_cd[k]));
                chk("mem_we",     k, 32'(mem_we_o[k]),     32'(m_we[k]));
                chk("mem_adr",    k, 32'(mem_adr_o[k]),    32'(m_adr[k]));
                chk("mem_wdata",  k, 32'(mem_wdata_o[k]),  32'(m_wd[k]));
                chk("rdata",      k, 32'(rdata_o[k]),      32'(m_rd[k]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge ph1);
        #2;
    endtask

    task automatic idle_reqs();
        core_req = 0; ld_req = 0;
    endtask

    task automatic settle(input int n);
        idle_reqs();
        for (int i = 0; i < n; i++) tick();
    endtask

    int seq [$];
    int exp_seq [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    int ld_t [2], cg_t [2];
    int we_cnt, done_idx, cnt_a, cnt_b;

    initial begin
        reset = 1; idle_reqs();
        core_we = 0; core_adr = '0; core_wdata = '0;
        ld_we = 0; ld_adr = '0; ld_wdata = '0; mem_rdata = '0;
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_mem_we", k, 32'(mem_we_o[k]), 0);
            chk("rst_rdata",  k, 32'(rdata_o[k]), 0);
            chk("rst_gnts",   k, 32'({core_gnt_o[k], ld_gnt_o[k], core_done_o[k], ld_done_o[k]}), 0);
            chk("rst_mem_adr", k, 32'(mem_adr_o[k]), 0);
        end
        reset = 0;
        cmp_en = 1;
        tick();

        // 1: single core read
        core_req = 1; core_we = 0; core_adr = 8'h10; mem_rdata = 15'h1234;
        tick();
        chk("t1_gnt", 0, 32'(core_gnt_o[0]), 1);
        chk("t1_adr", 0, 32'(mem_adr_o[0]), 32'h10);
        tick();
        chk("t1_done",  0, 32'(core_done_o[0]), 1);
        chk("t1_rdata", 0, 32'(rdata_o[0]), 32'h1234);
        chk("t1_stall", 0, 32'(core_stall_o[0]), 0);
        chk("t1_stall_l3", 1, 32'(core_stall_o[1]), 1);
        settle(6);

        // 2: loader write, rdata must keep the earlier read value
        mem_rdata = 15'h0555;
        ld_req = 1; ld_we = 1; ld_adr = 8'hFF; ld_wdata = 15'h7FFF;
        tick();
        chk("t2_gnt", 1, 32'(ld_gnt_o[1]), 1);
        ld_req = 0;
        we_cnt = 0; done_idx = -1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            if (mem_we_o[1]) begin
                we_cnt++;
                chk("t2_adr", 1, 32'(mem_adr_o[1]), 32'hFF);
            end
            if (ld_done_o[1] && done_idx < 0) done_idx = i;
        end
        chk("t2_we_cycles", 1, 32'(we_cnt), 3);
        chk("t2_done_idx",  1, 32'(done_idx), 3);
        chk("t2_rdata",     1, 32'(rdata_o[1]), 32'h1234);
        settle(3);

        // 3: both requesting continuously
        core_req = 1; core_we = 0; core_adr = 8'h21;
        ld_req = 1; ld_we = 0; ld_adr = 8'h42;
        for (int i = 0; i < 40 && seq.size() < 10; i++) begin
            tick();
            if (core_gnt_o[0]) seq.push_back(1);
            if (ld_gnt_o[0])   seq.push_back(2);
        end
        chk("t3_ngrants", 0, 32'(seq.size()), 10);
        for (int i = 0; i < 10; i++) begin
            chk("t3_order", 0, (i < seq.size()) ? 32'(seq[i]) : 32'hFFFF, 32'(exp_seq[i]));
        end
        settle(6);

        // 4: core waits behind a loader read
        ld_req = 1; ld_we = 0; ld_adr = 8'h20;
        tick();
        ld_req = 0; core_req = 1; core_we = 0; core_adr = 8'h30;
        ld_t = '{-1, -1}; cg_t = '{-1, -1};
        for (int i = 0; i < 12 && cg_t[1] < 0; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                if (ld_done_o[k] && ld_t[k] < 0) ld_t[k] = i;
                if (core_gnt_o[k] && cg_t[k] < 0) cg_t[k] = i;
            end
            if (cg_t[1] < 0) chk("t4_stall", 1, 32'(core_stall_o[1]), 1);
        end
        core_req = 0;
        chk("t4_gap",  0, 32'(cg_t[0] - ld_t[0]), 1);
        chk("t4_gap",  1, 32'(cg_t[1] - ld_t[1]), 1);
        chk("t4_gnt_t", 1, 32'(cg_t[1]), 3);
        settle(6);

        // 5: reset during a LAT=3 core write
        core_req = 1; core_we = 1; core_adr = 8'h40; core_wdata = 15'h0123;
        tick();
        core_req = 0;
        tick();
        chk("t5_we_busy", 1, 32'(mem_we_o[1]), 1);
        reset = 1;
        #1;
        chk("t5_we_async", 1, 32'(mem_we_o[1]), 0);
        chk("t5_adr_async", 1, 32'(mem_adr_o[1]), 0);
        tick();
        reset = 0;
        cnt_a = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (core_done_o[1]) cnt_a++;
        end
        chk("t5_no_done", 1, 32'(cnt_a), 0);
        settle(2);

        // 6: loader pulses its request while the core owns the port
        core_req = 1; core_we = 0; core_adr = 8'h50;
        ld_we = 1; ld_adr = 8'h66; ld_wdata = 15'h0066;
        tick();
        core_req = 0; ld_req = 1;
        tick();
        ld_req = 0;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 6; i++) begin
            if (ld_gnt_o[0] || ld_gnt_o[1]) cnt_a++;
            if (mem_adr_o[0] == 8'h66 || mem_adr_o[1] == 8'h66) cnt_b++;
            tick();
        end
        chk("t6_no_ld_gnt", 0, 32'(cnt_a), 0);
        chk("t6_no_ld_adr", 0, 32'(cnt_b), 0);
        settle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
